// File: rtl/cache_arbiter_if.sv
// Bundle of the cache-side and memory-side line-transfer signals of the
// cache arbiter. The slave modport is the arbiter's view; the master modport
// is the view of the environment: both caches plus the physical memory.
interface cache_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
);
   // instruction cache side (port a)
   logic                  pmem_read_a;
   logic [ADDR_WIDTH-1:0] pmem_addr_a;
   logic [LINE_WIDTH-1:0] pmem_rdata_a;
   logic                  pmem_resp_a;
   // data cache side (port b)
   logic                  pmem_read_b;
   logic                  pmem_write_b;
   logic [ADDR_WIDTH-1:0] pmem_addr_b;
   logic [LINE_WIDTH-1:0] pmem_wdata_b;
   logic [LINE_WIDTH-1:0] pmem_rdata_b;
   logic                  pmem_resp_b;
   // physical memory side
   logic                  phys_read;
   logic                  phys_write;
   logic [ADDR_WIDTH-1:0] phys_address;
   logic [LINE_WIDTH-1:0] phys_wdata;
   logic [LINE_WIDTH-1:0] phys_rdata;
   logic                  phys_resp;

   modport slave (
      input  pmem_read_a, pmem_addr_a,
      input  pmem_read_b, pmem_write_b, pmem_addr_b, pmem_wdata_b,
      input  phys_rdata, phys_resp,
      output pmem_rdata_a, pmem_resp_a, pmem_rdata_b, pmem_resp_b,
      output phys_read, phys_write, phys_address, phys_wdata
   );

   modport master (
      output pmem_read_a, pmem_addr_a,
      output pmem_read_b, pmem_write_b, pmem_addr_b, pmem_wdata_b,
      output phys_rdata, phys_resp,
      input  pmem_rdata_a, pmem_resp_a, pmem_rdata_b, pmem_resp_b,
      input  phys_read, phys_write, phys_address, phys_wdata
   );
endinterface

// File: rtl/cache_arbiter.sv
// Two-client line arbiter: serialises instruction-cache reads (port a) and
// data-cache reads/writebacks (port b) onto one physical memory port with
// round-robin priority, and steers each completion back to its requester.
// Every output is driven straight from a register.
module cache_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
) (
   input logic            clk,
   input logic            rst_n,
   cache_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B, DONE} state_t;

   // clears the byte-in-line offset so memory only ever sees aligned lines
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH-5){1'b1}}, 5'b0};

   state_t                state, state_nxt;
   logic                  last_grant, last_grant_nxt;   // 0 = a, 1 = b
   logic [ADDR_WIDTH-1:0] req_addr, req_addr_nxt;
   logic [LINE_WIDTH-1:0] req_wdata, req_wdata_nxt;
   logic                  rd_strobe, rd_strobe_nxt;
   logic                  wr_strobe, wr_strobe_nxt;
   logic [LINE_WIDTH-1:0] rdata_a, rdata_a_nxt;
   logic [LINE_WIDTH-1:0] rdata_b, rdata_b_nxt;
   logic                  resp_a, resp_a_nxt;
   logic                  resp_b, resp_b_nxt;

   logic req_a;
   logic req_b;
   logic grant_b;

   assign req_a = bus.pmem_read_a;
   assign req_b = bus.pmem_read_b | bus.pmem_write_b;
   // b wins when it is alone, or when both ask and a was granted last
   assign grant_b = req_b & (~req_a | ~last_grant);

   assign bus.phys_read    = rd_strobe;
   assign bus.phys_write   = wr_strobe;
   assign bus.phys_address = req_addr;
   assign bus.phys_wdata   = req_wdata;
   assign bus.pmem_rdata_a = rdata_a;
   assign bus.pmem_rdata_b = rdata_b;
   assign bus.pmem_resp_a  = resp_a;
   assign bus.pmem_resp_b  = resp_b;

   // Next-state and next-output decode; everything holds unless a transition says otherwise.
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      req_addr_nxt   = req_addr;
      req_wdata_nxt  = req_wdata;
      rd_strobe_nxt  = rd_strobe;
      wr_strobe_nxt  = wr_strobe;
      rdata_a_nxt    = rdata_a;
      rdata_b_nxt    = rdata_b;
      resp_a_nxt     = 1'b0;
      resp_b_nxt     = 1'b0;

      case (state)
         IDLE: begin
            if (grant_b) begin
               state_nxt      = SERVE_B;
               last_grant_nxt = 1'b1;
               req_addr_nxt   = bus.pmem_addr_b & LINE_MASK;
               req_wdata_nxt  = bus.pmem_wdata_b;
               // a writeback takes precedence over a simultaneous read
               wr_strobe_nxt  = bus.pmem_write_b;
               rd_strobe_nxt  = ~bus.pmem_write_b;
            end else if (req_a) begin
               state_nxt      = SERVE_A;
               last_grant_nxt = 1'b0;
               req_addr_nxt   = bus.pmem_addr_a & LINE_MASK;
               req_wdata_nxt  = '0;
               rd_strobe_nxt  = 1'b1;
               wr_strobe_nxt  = 1'b0;
            end
         end
         SERVE_A: begin
            if (bus.phys_resp) begin
               state_nxt     = DONE;
               rd_strobe_nxt = 1'b0;
               wr_strobe_nxt = 1'b0;
               rdata_a_nxt   = bus.phys_rdata;
               resp_a_nxt    = 1'b1;
            end
         end
         SERVE_B: begin
            if (bus.phys_resp) begin
               state_nxt     = DONE;
               rd_strobe_nxt = 1'b0;
               wr_strobe_nxt = 1'b0;
               rdata_b_nxt   = bus.phys_rdata;
               resp_b_nxt    = 1'b1;
            end
         end
         DONE: begin
            // the completion pulse is on the outputs this cycle; requests are
            // looked at again only once back in IDLE
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any in-flight transfer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         req_addr   <= '0;
         req_wdata  <= '0;
         rd_strobe  <= 1'b0;
         wr_strobe  <= 1'b0;
         rdata_a    <= '0;
         rdata_b    <= '0;
         resp_a     <= 1'b0;
         resp_b     <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         req_addr   <= req_addr_nxt;
         req_wdata  <= req_wdata_nxt;
         rd_strobe  <= rd_strobe_nxt;
         wr_strobe  <= wr_strobe_nxt;
         rdata_a    <= rdata_a_nxt;
         rdata_b    <= rdata_b_nxt;
         resp_a     <= resp_a_nxt;
         resp_b     <= resp_b_nxt;
      end
   end
endmodule
